// File: rtl/display_window_scaler_pkg.sv
// -----------------------------------------------------------------------------
// display_window_scaler_pkg
//   Shared types and constants for the scaled game window compositor.
//
//   rgb_t        packed {R,G,B} nibble triple, laid out like the 12-bit colour
//                buses so a plain cast converts between the two.
//   pix_flags_t  per-pixel compositing flags that travel down the delay line
//                alongside the game renderer.
//   SUB_W        width of the sub-pixel counter (enough for SCALE up to 4).
//   PACMAN_*     default geometry/colour constants for the pacman build.
//   select_rgb   priority colour mux used by the output register.
// -----------------------------------------------------------------------------
package display_window_scaler_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic de;      // raster inside the VGA visible area
        logic win;     // inside the game window and the window is synced
        logic border;  // inside the border ring around the window
    } pix_flags_t;

    localparam int SUB_W         = 2;
    localparam int MAX_SCALE     = 4;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_V_VISIBLE = 480;

    localparam int          PACMAN_SCALE      = 1;
    localparam logic [11:0] PACMAN_BORDER_RGB = 12'h00F;
    localparam logic [11:0] PACMAN_BG_RGB     = 12'h000;

    // Blanking wins over everything; the game window wins over the border,
    // and the border wins over the background.
    function automatic rgb_t select_rgb(input pix_flags_t  flags,
                                        input logic [11:0] game,
                                        input logic [11:0] border,
                                        input logic [11:0] bg);
        rgb_t sel;
        if (!flags.de) begin
            sel = '0;
        end else if (flags.win) begin
            sel = rgb_t'(game);
        end else if (flags.border) begin
            sel = rgb_t'(border);
        end else begin
            sel = rgb_t'(bg);
        end
        return sel;
    endfunction

endpackage

// File: rtl/display_window_scaler_axis.sv
// -----------------------------------------------------------------------------
// scale_axis_counter
//   One axis of the upscaled window coordinate generator. A sub-pixel counter
//   runs 0..SCALE-1; each time it wraps the game coordinate steps by one.
//   Replaces a divide-by-SCALE with a pair of incrementing counters.
//
//   Ports
//     clk, rst     clock, asynchronous active-high reset
//     load         force sub and coord to 0 (takes priority over advance)
//     advance      step the sub-pixel counter by one
//     sub, coord   registered counter state
//     wrap         this step wraps sub back to 0 and bumps coord
//     sub_next,
//     coord_next   value the state takes at the next edge; used by the top
//                  when it needs the coordinate of the pixel being presented
// -----------------------------------------------------------------------------
module scale_axis_counter
    import display_window_scaler_pkg::*;
#(
    parameter int SCALE = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [SUB_W-1:0] sub,
    output logic [WIDTH-1:0] coord,
    output logic             wrap,
    output logic [SUB_W-1:0] sub_next,
    output logic [WIDTH-1:0] coord_next
);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SCALE - 1);

    always_comb begin
        sub_next   = sub;
        coord_next = coord;
        wrap       = 1'b0;
        if (load) begin
            sub_next   = '0;
            coord_next = '0;
        end else if (advance) begin
            if (sub == SUB_MAX) begin
                sub_next   = '0;
                coord_next = coord + 1'b1;
                wrap       = 1'b1;
            end else begin
                sub_next = sub + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub   <= '0;
            coord <= '0;
        end else begin
            sub   <= sub_next;
            coord <= coord_next;
        end
    end

endmodule

// File: rtl/display_window_scaler.sv
// -----------------------------------------------------------------------------
// display_window_scaler
//   Maps the VGA raster onto an integer-upscaled game window, emits game
//   pixel / line / frame strobes, and composites the final pixel colour
//   (game, border ring or background) aligned to the game renderer latency.
//
//   Ports
//     vga_pix_clk       pixel clock
//     rst               asynchronous active-high reset
//     vga_sx, vga_sy    raster position from the VGA timing generator
//     display_enabled   raster is in the VGA visible area
//     game_rgb          {R,G,B} from the game, GAME_LATENCY cycles after the
//                       window coordinates
//     window_sx/sy      game coordinate of the pixel (1 cycle after raster);
//                       hold their last value while window_enabled is low
//     window_enabled    coordinates valid and inside the window
//     game_pix_stb      first VGA pixel of each game pixel
//     line_stb          first window pixel of each VGA line in the window
//     frame_start       first sub-pixel of game pixel (0,0)
//     R, G, B           composited colour, GAME_LATENCY+2 cycles after raster
//
//   Timing / handshake: there is no back-pressure. Every pixel clock carries
//   one raster position in; the coordinate/strobe outputs for that position
//   appear one cycle later, the colour GAME_LATENCY+2 cycles later.
// -----------------------------------------------------------------------------
module display_window_scaler
    import display_window_scaler_pkg::*;
#(
    parameter int          H_VGA_ADDR_WIDTH      = 10,
    parameter int          V_VGA_ADDR_WIDTH      = 10,
    parameter int          H_WINDOW_VISIBLE_AREA = 224,
    parameter int          V_WINDOW_VISIBLE_AREA = 288,
    parameter int          SCALE                 = PACMAN_SCALE,
    parameter int          H_WINDOW_OFFSET       = 208,
    parameter int          V_WINDOW_OFFSET       = 96,
    parameter int          GAME_LATENCY          = 2,
    parameter int          BORDER_WIDTH          = 2,
    parameter logic [11:0] BORDER_RGB            = PACMAN_BORDER_RGB,
    parameter logic [11:0] BG_RGB                = PACMAN_BG_RGB
) (
    input  logic                                     vga_pix_clk,
    input  logic                                     rst,
    input  logic [H_VGA_ADDR_WIDTH-1:0]              vga_sx,
    input  logic [V_VGA_ADDR_WIDTH-1:0]              vga_sy,
    input  logic                                     display_enabled,
    input  logic [11:0]                              game_rgb,
    output logic [$clog2(H_WINDOW_VISIBLE_AREA)-1:0] window_sx,
    output logic [$clog2(V_WINDOW_VISIBLE_AREA)-1:0] window_sy,
    output logic                                     window_enabled,
    output logic                                     game_pix_stb,
    output logic                                     line_stb,
    output logic                                     frame_start,
    output logic [3:0]                               R,
    output logic [3:0]                               G,
    output logic [3:0]                               B
);

    localparam int SX_W = $clog2(H_WINDOW_VISIBLE_AREA);
    localparam int SY_W = $clog2(V_WINDOW_VISIBLE_AREA);

    // Window extents in VGA pixels; *_END is exclusive.
    localparam int X_END  = H_WINDOW_OFFSET + H_WINDOW_VISIBLE_AREA * SCALE;
    localparam int Y_END  = V_WINDOW_OFFSET + V_WINDOW_VISIBLE_AREA * SCALE;
    localparam int X_LAST = X_END - 1;
    localparam int Y_LAST = Y_END - 1;

    // Border box: the window grown by BORDER_WIDTH on every side.
    localparam int BX_LO = H_WINDOW_OFFSET - BORDER_WIDTH;
    localparam int BX_HI = X_END + BORDER_WIDTH;
    localparam int BY_LO = V_WINDOW_OFFSET - BORDER_WIDTH;
    localparam int BY_HI = Y_END + BORDER_WIDTH;

    // ------------------------------------------------------------------
    // Parameter sanity checks
    // ------------------------------------------------------------------
    if (SCALE < 1 || SCALE > MAX_SCALE) begin : g_bad_scale
        $error("display_window_scaler: SCALE must be 1..4");
    end
    if (X_END > VGA_H_VISIBLE) begin : g_bad_h_fit
        $error("display_window_scaler: window exceeds VGA width");
    end
    if (Y_END > VGA_V_VISIBLE) begin : g_bad_v_fit
        $error("display_window_scaler: window exceeds VGA height");
    end
    if (BORDER_WIDTH > H_WINDOW_OFFSET || BORDER_WIDTH > V_WINDOW_OFFSET) begin : g_bad_border
        $error("display_window_scaler: border does not fit before the window");
    end

    // ------------------------------------------------------------------
    // Raster classification (combinational, current raster position)
    // ------------------------------------------------------------------
    logic h_in, v_in, in_region;
    logic in_border_box, in_border;
    logic h_load, v_load;
    logic line_last, frame_last_line;
    logic h_adv, v_adv;
    logic synced, synced_eff, pix_en;

    assign h_in = (int'(vga_sx) >= H_WINDOW_OFFSET) && (int'(vga_sx) < X_END);
    assign v_in = (int'(vga_sy) >= V_WINDOW_OFFSET) && (int'(vga_sy) < Y_END);
    assign in_region = h_in && v_in;

    assign in_border_box = (int'(vga_sx) >= BX_LO) && (int'(vga_sx) < BX_HI) &&
                           (int'(vga_sy) >= BY_LO) && (int'(vga_sy) < BY_HI);
    assign in_border = in_border_box && !in_region;

    assign h_load          = (int'(vga_sx) == H_WINDOW_OFFSET);
    assign v_load          = h_load && (int'(vga_sy) == V_WINDOW_OFFSET);
    assign line_last       = (int'(vga_sx) == X_LAST);
    assign frame_last_line = (int'(vga_sy) == Y_LAST);

    assign h_adv = in_region;
    // No vertical step after the final window line, so window_sy parks on
    // its last row until the next frame reloads it.
    assign v_adv = in_region && line_last && !frame_last_line;

    // The (HO,VO) pixel itself must already count as synced.
    assign synced_eff = synced || v_load;
    assign pix_en     = in_region && display_enabled && synced_eff;

    // ------------------------------------------------------------------
    // Axis counters
    // ------------------------------------------------------------------
    logic [SUB_W-1:0] h_sub, h_sub_next, v_sub, v_sub_next;
    logic [SX_W-1:0]  h_coord, h_coord_next;
    logic [SY_W-1:0]  v_coord, v_coord_next;
    logic             h_wrap, v_wrap;

    scale_axis_counter #(
        .SCALE (SCALE),
        .WIDTH (SX_W)
    ) u_h_axis (
        .clk        (vga_pix_clk),
        .rst        (rst),
        .load       (h_load),
        .advance    (h_adv),
        .sub        (h_sub),
        .coord      (h_coord),
        .wrap       (h_wrap),
        .sub_next   (h_sub_next),
        .coord_next (h_coord_next)
    );

    scale_axis_counter #(
        .SCALE (SCALE),
        .WIDTH (SY_W)
    ) u_v_axis (
        .clk        (vga_pix_clk),
        .rst        (rst),
        .load       (v_load),
        .advance    (v_adv),
        .sub        (v_sub),
        .coord      (v_coord),
        .wrap       (v_wrap),
        .sub_next   (v_sub_next),
        .coord_next (v_coord_next)
    );

    // Horizontal: the counter state after this edge is the coordinate of the
    // pixel being presented. Vertical: the counter steps on the last pixel
    // of a line, so the line's own coordinate is the current state, except
    // on the (HO,VO) pixel where the reload value applies.
    logic [SUB_W-1:0] pix_v_sub;
    logic [SY_W-1:0]  pix_v_coord;
    logic             pix_first;

    assign pix_v_sub   = v_load ? '0 : v_sub;
    assign pix_v_coord = v_load ? '0 : v_coord;
    assign pix_first   = (h_sub_next == '0) && (h_coord_next == '0);

    // Counter views this block does not consume.
    logic unused_axis;
    assign unused_axis = ^{h_sub, h_coord, h_wrap, v_wrap, v_sub_next, v_coord_next};

    // ------------------------------------------------------------------
    // Registered coordinates and strobes (1 cycle after raster)
    // ------------------------------------------------------------------
    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            synced         <= 1'b0;
            window_enabled <= 1'b0;
            game_pix_stb   <= 1'b0;
            line_stb       <= 1'b0;
            frame_start    <= 1'b0;
            window_sx      <= '0;
            window_sy      <= '0;
        end else begin
            synced         <= synced_eff;
            window_enabled <= pix_en;
            game_pix_stb   <= pix_en && (h_sub_next == '0);
            line_stb       <= pix_en && pix_first;
            frame_start    <= pix_en && pix_first &&
                              (pix_v_coord == '0) && (pix_v_sub == '0);
            if (pix_en) begin
                window_sx <= h_coord_next;
                window_sy <= pix_v_coord;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compositing: flags ride a 1+GAME_LATENCY deep delay line so that the
    // last stage lines up with game_rgb for the same pixel; the output
    // register adds one more cycle.
    // ------------------------------------------------------------------
    pix_flags_t flags_now;
    pix_flags_t flag_pipe [0:GAME_LATENCY];
    rgb_t       rgb_q;

    assign flags_now = {display_enabled, in_region && synced_eff, in_border};

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= GAME_LATENCY; i++) begin
                flag_pipe[i] <= '0;
            end
            rgb_q <= '0;
        end else begin
            flag_pipe[0] <= flags_now;
            for (int i = 1; i <= GAME_LATENCY; i++) begin
                flag_pipe[i] <= flag_pipe[i-1];
            end
            rgb_q <= select_rgb(flag_pipe[GAME_LATENCY], game_rgb, BORDER_RGB, BG_RGB);
        end
    end

    assign R = rgb_q.r;
    assign G = rgb_q.g;
    assign B = rgb_q.b;

endmodule

// File: tb/tb_display_window_scaler.sv
// -----------------------------------------------------------------------------
// tb_display_window_scaler
//   Directed bench for display_window_scaler. Four instances with different
//   geometry share one raster stimulus:
//     dut_a  defaults (SCALE=1, 224x288 at 208,96, border 2)
//     dut_b  SCALE=2, 224x240 at 96,0, no border
//     dut_c  SCALE=1, 160x160 at 100,50, border 2
//     dut_d  SCALE=3, 16x12 at 20,10, border 1
// -----------------------------------------------------------------------------
module tb_display_window_scaler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]  vga_sx, vga_sy;
    logic        display_enabled;
    logic [11:0] game_rgb;

    int tests_run    = 0;
    int tests_failed = 0;

    // strobe counters for the frame scans
    int cnt_c_pix, cnt_c_line, cnt_c_frame, cnt_c_en;
    int cnt_d_pix, cnt_d_line, cnt_d_frame;

    // ---------------- DUT outputs ----------------
    logic [7:0]  a_sx;  logic [8:0] a_sy;
    logic        a_en, a_pix, a_line, a_frame;
    logic [3:0]  a_r, a_g, a_b;

    logic [7:0]  b_sx, b_sy;
    logic        b_en, b_pix, b_line, b_frame;
    logic [11:0] b_rgb_unused;

    logic [7:0]  c_sx, c_sy;
    logic        c_en, c_pix, c_line, c_frame;
    logic [11:0] c_rgb_unused;

    logic [3:0]  d_sx, d_sy;
    logic        d_en_unused, d_pix, d_line, d_frame;
    logic [11:0] d_rgb_unused;

    display_window_scaler dut_a (
        .vga_pix_clk(clk), .rst(rst), .vga_sx(vga_sx), .vga_sy(vga_sy),
        .display_enabled(display_enabled), .game_rgb(game_rgb),
        .window_sx(a_sx), .window_sy(a_sy), .window_enabled(a_en),
        .game_pix_stb(a_pix), .line_stb(a_line), .frame_start(a_frame),
        .R(a_r), .G(a_g), .B(a_b)
    );

    display_window_scaler #(
        .SCALE(2), .H_WINDOW_OFFSET(96), .V_WINDOW_OFFSET(0),
        .V_WINDOW_VISIBLE_AREA(240), .BORDER_WIDTH(0)
    ) dut_b (
        .vga_pix_clk(clk), .rst(rst), .vga_sx(vga_sx), .vga_sy(vga_sy),
        .display_enabled(display_enabled), .game_rgb(game_rgb),
        .window_sx(b_sx), .window_sy(b_sy), .window_enabled(b_en),
        .game_pix_stb(b_pix), .line_stb(b_line), .frame_start(b_frame),
        .R(b_rgb_unused[11:8]), .G(b_rgb_unused[7:4]), .B(b_rgb_unused[3:0])
    );

    display_window_scaler #(
        .H_WINDOW_VISIBLE_AREA(160), .V_WINDOW_VISIBLE_AREA(160),
        .H_WINDOW_OFFSET(100), .V_WINDOW_OFFSET(50)
    ) dut_c (
        .vga_pix_clk(clk), .rst(rst), .vga_sx(vga_sx), .vga_sy(vga_sy),
        .display_enabled(display_enabled), .game_rgb(game_rgb),
        .window_sx(c_sx), .window_sy(c_sy), .window_enabled(c_en),
        .game_pix_stb(c_pix), .line_stb(c_line), .frame_start(c_frame),
        .R(c_rgb_unused[11:8]), .G(c_rgb_unused[7:4]), .B(c_rgb_unused[3:0])
    );

    display_window_scaler #(
        .H_WINDOW_VISIBLE_AREA(16), .V_WINDOW_VISIBLE_AREA(12), .SCALE(3),
        .H_WINDOW_OFFSET(20), .V_WINDOW_OFFSET(10), .BORDER_WIDTH(1)
    ) dut_d (
        .vga_pix_clk(clk), .rst(rst), .vga_sx(vga_sx), .vga_sy(vga_sy),
        .display_enabled(display_enabled), .game_rgb(game_rgb),
        .window_sx(d_sx), .window_sy(d_sy), .window_enabled(d_en_unused),
        .game_pix_stb(d_pix), .line_stb(d_line), .frame_start(d_frame),
        .R(d_rgb_unused[11:8]), .G(d_rgb_unused[7:4]), .B(d_rgb_unused[3:0])
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one raster position, clock it in, sample 1 ns after the edge.
    task automatic pix(input int x, input int y, input logic de);
        vga_sx          = 10'(x);
        vga_sy          = 10'(y);
        display_enabled = de;
        @(posedge clk);
        #1;
        if (c_pix)   cnt_c_pix++;
        if (c_line)  cnt_c_line++;
        if (c_frame) cnt_c_frame++;
        if (c_en)    cnt_c_en++;
        if (d_pix)   cnt_d_pix++;
        if (d_line)  cnt_d_line++;
        if (d_frame) cnt_d_frame++;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                pix(x, y, 1'b1);
            end
        end
    endtask

    task automatic clear_counts();
        cnt_c_pix = 0; cnt_c_line = 0; cnt_c_frame = 0; cnt_c_en = 0;
        cnt_d_pix = 0; cnt_d_line = 0; cnt_d_frame = 0;
    endtask

    // Colour of one pixel on dut_a: blank before it, must still be blank
    // 3 cycles after presenting, and show the colour exactly 4 cycles after.
    task automatic rgb_probe(input string tag, input int x, input int y,
                             input logic de, input logic [11:0] exp);
        repeat (4) pix(0, 0, 1'b0);
        pix(x, y, de);
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
        check({tag, "_early"}, {a_r, a_g, a_b}, 12'h000);
        pix(0, 0, 1'b0);
        check(tag, {a_r, a_g, a_b}, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst             = 1'b1;
        vga_sx          = '0;
        vga_sy          = '0;
        display_enabled = 1'b0;
        game_rgb        = 12'hABC;
        clear_counts();
        #12;
        check("rst_en",    a_en, 0);
        check("rst_sx",    a_sx, 0);
        check("rst_sy",    a_sy, 0);
        check("rst_frame", a_frame, 0);
        check("rst_rgb",   {a_r, a_g, a_b}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- SCALE=1 defaults, first line of the window ----
        pix(208, 96, 1'b1);
        check("s1_first_en",    a_en, 1);
        check("s1_first_sx",    a_sx, 0);
        check("s1_first_sy",    a_sy, 0);
        check("s1_first_frame", a_frame, 1);
        check("s1_first_line",  a_line, 1);
        check("s1_first_pix",   a_pix, 1);
        pix(209, 96, 1'b1);
        check("s1_second_sx",    a_sx, 1);
        check("s1_second_frame", a_frame, 0);
        for (int x = 210; x <= 430; x++) pix(x, 96, 1'b1);
        pix(431, 96, 1'b1);
        check("s1_last_sx", a_sx, 223);
        check("s1_last_en", a_en, 1);
        pix(432, 96, 1'b1);
        check("s1_past_en", a_en, 0);
        check("s1_past_sx_hold", a_sx, 223);
        pix(208, 97, 1'b1);
        check("s1_row1_sy",    a_sy, 1);
        check("s1_row1_line",  a_line, 1);
        check("s1_row1_frame", a_frame, 0);

        // ---- compositing latency and colour selection ----
        rgb_probe("rgb_game",      300, 98, 1'b1, 12'hABC);
        rgb_probe("rgb_border_l1", 207, 98, 1'b1, 12'h00F);
        rgb_probe("rgb_border_l2", 206, 98, 1'b1, 12'h00F);
        rgb_probe("rgb_bg",        205, 98, 1'b1, 12'h000);
        rgb_probe("rgb_border_r",  432, 98, 1'b1, 12'h00F);
        rgb_probe("rgb_border_t",  300, 95, 1'b1, 12'h00F);

        // ---- display_enabled low inside the window ----
        pix(250, 98, 1'b0);
        check("de0_en",  a_en, 0);
        check("de0_pix", a_pix, 0);
        pix(208, 99, 1'b0);
        check("de0_line", a_line, 0);
        check("de0_pix2", a_pix, 0);
        rgb_probe("de0_rgb", 250, 98, 1'b0, 12'h000);

        // ---- SCALE=2 at HO=96, VO=0 ----
        pix(96, 0, 1'b1);
        check("s2_96_sx",    b_sx, 0);
        check("s2_96_pix",   b_pix, 1);
        check("s2_96_sy",    b_sy, 0);
        check("s2_96_frame", b_frame, 1);
        check("s2_96_en",    b_en, 1);
        pix(97, 0, 1'b1);
        check("s2_97_sx",  b_sx, 0);
        check("s2_97_pix", b_pix, 0);
        pix(98, 0, 1'b1);
        check("s2_98_sx",  b_sx, 1);
        check("s2_98_pix", b_pix, 1);
        for (int x = 99; x <= 543; x++) pix(x, 0, 1'b1);
        check("s2_line0_last_sx", b_sx, 223);
        pix(96, 1, 1'b1);
        check("s2_sy1_sy",    b_sy, 0);
        check("s2_sy1_line",  b_line, 1);
        check("s2_sy1_frame", b_frame, 0);
        for (int x = 97; x <= 543; x++) pix(x, 1, 1'b1);
        pix(96, 2, 1'b1);
        check("s2_sy2_sy",   b_sy, 1);
        check("s2_sy2_line", b_line, 1);

        // ---- full frame, 160x160 SCALE=1 ----
        clear_counts();
        scan(98, 261, 48, 211);
        check("c_frame_pix_cnt",   cnt_c_pix, 25600);
        check("c_frame_line_cnt",  cnt_c_line, 160);
        check("c_frame_start_cnt", cnt_c_frame, 1);
        check("c_end_sx", c_sx, 159);
        check("c_end_sy", c_sy, 159);

        // ---- full frames, 16x12 SCALE=3 (twice) ----
        for (int f = 0; f < 2; f++) begin
            clear_counts();
            scan(18, 69, 8, 47);
            check("d_frame_pix_cnt",   cnt_d_pix, 576);
            check("d_frame_line_cnt",  cnt_d_line, 36);
            check("d_frame_start_cnt", cnt_d_frame, 1);
            check("d_end_sx", d_sx, 15);
            check("d_end_sy", d_sy, 11);
        end

        // ---- reset in mid-frame on dut_c ----
        pix(100, 50, 1'b1);
        check("rst_mid_sync_frame", c_frame, 1);
        for (int x = 101; x <= 179; x++) pix(x, 150, 1'b1);
        check("rst_mid_pre_en", c_en, 1);
        rst = 1'b1;
        #2;
        check("rst_mid_async_en", c_en, 0);
        rst = 1'b0;
        clear_counts();
        for (int x = 180; x <= 261; x++) pix(x, 150, 1'b1);
        scan(98, 261, 151, 211);
        check("rst_mid_rest_en_cnt", cnt_c_en, 0);
        check("rst_mid_rest_frame_cnt", cnt_c_frame, 0);
        pix(100, 50, 1'b1);
        check("rst_next_frame", c_frame, 1);
        check("rst_next_sy",    c_sy, 0);
        check("rst_next_en",    c_en, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
